// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_e;

    // Width of a counter that must hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = x - y - bi, with borrow-out bo.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    // Borrow is generated when y exceeds x, and propagated when x equals y.
    always_comb begin
        diff = x ^ y ^ bi;
        bo   = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, d = a - b - bin, LSB first, one bit per clock.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter  int N  = 8,
    localparam int CW = cnt_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         ovf,
    output logic         zero
);

    serial_state_e state;
    serial_state_e state_next;

    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [N-1:0]  res;
    logic [N-1:0]  res_next;
    logic          brw;
    logic [CW-1:0] cnt;
    logic          last_bit;

    logic          di;
    logic          brw_next;

    logic [N-1:0]  d_q;
    logic          bout_q;
    logic          ovf_q;
    logic          zero_q;

    full_subtractor u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bi   (brw),
        .diff (di),
        .bo   (brw_next)
    );

    // Result register after this step's bit is shifted in; on the MSB step it is the final difference.
    always_comb begin
        res_next = {di, res[N-1:1]};
        last_bit = (cnt == CW'(N - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; in_ready is also gated by reset so nothing is accepted during it.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, per-bit shifting, and final flag capture on the MSB step.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa  <= a;
                        sb  <= b;
                        brw <= bin;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= res_next;
                    brw <= brw_next;
                    cnt <= cnt + CW'(1);
                    if (last_bit) begin
                        d_q    <= res_next;
                        bout_q <= brw_next;
                        ovf_q  <= brw ^ brw_next;
                        zero_q <= (res_next == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Published results hold until the next transaction completes.
    always_comb begin
        d    = d_q;
        bout = bout_q;
        ovf  = ovf_q;
        zero = zero_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor with a scoreboard of expected results.
module tb_serial_subtractor;

    localparam int N = 8;

    typedef struct packed {
        logic [N-1:0] d;
        logic         bout;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] d;
    logic         bout;
    logic         ovf;
    logic         zero;

    int   checks;
    int   errors;
    exp_t exp_q[$];

    serial_subtractor #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [N-1:0] dd, input logic bo, input logic ov, input logic z);
        exp_t e;
        e.d    = dd;
        e.bout = bo;
        e.ovf  = ov;
        e.zero = z;
        return e;
    endfunction

    // Arithmetic reference: integer subtraction, unsigned and signed views.
    function automatic exp_t model(input logic [N-1:0] xa, input logic [N-1:0] xb, input logic xbin);
        exp_t e;
        int   ua;
        int   ub;
        int   sa;
        int   sb;
        int   diff;
        int   sdiff;
        ua    = int'(xa);
        ub    = int'(xb);
        sa    = xa[N-1] ? ua - (1 << N) : ua;
        sb    = xb[N-1] ? ub - (1 << N) : ub;
        diff  = ua - ub - int'(xbin);
        sdiff = sa - sb - int'(xbin);
        e.d    = N'(diff + (1 << N));
        e.bout = (ua < ub + int'(xbin));
        e.ovf  = (sdiff < -(1 << (N - 1))) || (sdiff > (1 << (N - 1)) - 1);
        e.zero = (e.d == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Offer one operand tuple; on acceptance push its expected result.
    task automatic apply_stimulus(input logic [N-1:0] xa, input logic [N-1:0] xb, input logic xbin,
                                  input exp_t e);
        bit done;
        done     = 1'b0;
        a        = xa;
        b        = xb;
        bin      = xbin;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (done) begin
            exp_q.push_back(e);
        end else begin
            check("accept_timeout", 32'(0), 32'(1));
        end
    endtask

    // Wait for a result, compare it with the scoreboard, stall, then complete the handshake.
    task automatic check_output(input int stall, input bit pulse_in);
        exp_t         e;
        logic [N-1:0] held_d;
        int           waited;
        waited = 0;
        while (!out_valid && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!out_valid) begin
            check("result_timeout", 32'(0), 32'(1));
            return;
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'(0), 32'(1));
            return;
        end
        e = exp_q.pop_front();
        check("d", 32'(d), 32'(e.d));
        check("bout", 32'(bout), 32'(e.bout));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("zero", 32'(zero), 32'(e.zero));
        held_d = d;
        for (int i = 0; i < stall; i++) begin
            if (pulse_in) begin
                in_valid = (i % 2) == 0;
                a        = N'($urandom);
                b        = N'($urandom);
            end
            @(posedge clk);
            #1;
            check("stall_out_valid", 32'(out_valid), 32'(1));
            check("stall_d", 32'(d), 32'(held_d));
            check("stall_in_ready", 32'(in_ready), 32'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_out_valid", 32'(out_valid), 32'(0));
        check("post_hs_in_ready", 32'(in_ready), 32'(1));
        check("post_hs_d_hold", 32'(d), 32'(held_d));
    endtask

    initial begin
        int   lat;
        exp_t dummy;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rbin;

        clk       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        checks    = 0;
        errors    = 0;

        // Reset behaviour.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'(1));
        check("idle_d", 32'(d), 32'(0));
        check("idle_bout", 32'(bout), 32'(0));

        // Basic subtraction with latency: accept in cycle t, out_valid in cycle t+N+1.
        apply_stimulus(8'h35, 8'h12, 1'b0, mk(8'h23, 1'b0, 1'b0, 1'b0));
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat + 1), 32'(N + 1));
        check_output(0, 1'b0);

        // Borrow-out and signed overflow.
        apply_stimulus(8'h00, 8'h01, 1'b0, mk(8'hFF, 1'b1, 1'b0, 1'b0));
        check_output(0, 1'b0);
        apply_stimulus(8'h80, 8'h01, 1'b0, mk(8'h7F, 1'b0, 1'b1, 1'b0));
        check_output(0, 1'b0);

        // Zero result, then the same operands with a borrow-in.
        apply_stimulus(8'h5A, 8'h5A, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b1));
        check_output(0, 1'b0);
        apply_stimulus(8'h5A, 8'h5A, 1'b1, mk(8'hFF, 1'b1, 1'b0, 1'b0));
        check_output(0, 1'b0);

        // Backpressure with in_valid pulses that must be ignored.
        apply_stimulus(8'h35, 8'h12, 1'b0, mk(8'h23, 1'b0, 1'b0, 1'b0));
        check_output(5, 1'b1);

        // Reset in the middle of a run discards the transaction.
        apply_stimulus(8'hC3, 8'h21, 1'b0, mk(8'hA2, 1'b0, 1'b0, 1'b0));
        dummy = exp_q.pop_back();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrun_out_valid", 32'(out_valid), 32'(0));
        check("midrun_in_ready", 32'(in_ready), 32'(1));
        check("midrun_d", 32'(d), 32'(0));
        check("midrun_bout", 32'(bout), 32'(0));
        apply_stimulus(8'h10, 8'h01, 1'b0, mk(8'h0F, 1'b0, 1'b0, 1'b0));
        check_output(0, 1'b0);

        // Random regression against the arithmetic reference.
        for (int t = 0; t < 1000; t++) begin
            ra   = N'($urandom);
            rb   = N'($urandom);
            rbin = 1'($urandom);
            apply_stimulus(ra, rb, rbin, model(ra, rb, rbin));
            check_output(int'($urandom_range(0, 3)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor with borrow-in and borrow-out. It computes d = a - b - bin, one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- It is the subtract-direction counterpart to the team's ripple-carry adders. It trades the N-cell ripple chain for N cycles of latency and one cell.
- It sits between operand producers and result consumers, with valid/ready handshakes on both sides.

Parameters:
- N, 8, operand and result width in bits; legal range N >= 2.
- CW, $clog2(N+1), bit-counter width; derived, not to be overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand tuple {a, b, bin} is valid.
- in_ready  out  1  block can accept operands; high only in IDLE and low while rst is high.
- a  in  N  minuend; sampled on the accept edge.
- b  in  N  subtrahend; sampled on the accept edge.
- bin  in  1  borrow-in; sampled on the accept edge.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  consumer accepts the result.
- d  out  N  difference, a - b - bin, modulo 2^N.
- bout  out  1  borrow-out; 1 iff unsigned a < b + bin.
- ovf  out  1  signed (two's-complement) overflow.
- zero  out  1  d == 0.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (rst=1 at an edge), from any state including mid-RUN:
  - state goes to IDLE; operand shift registers, d, bout, ovf, zero, borrow flop and counter all clear to 0.
  - out_valid=0; in_ready=1 from the first cycle after rst deasserts.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch a into sa and b into sb, load borrow flop with bin, clear counter, go to RUN.
- RUN, once per cycle:
  - di = sa[0] ^ sb[0] ^ brw.
  - brw_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw).
  - Shift sa and sb right by 1; shift di into the MSB of the result register; brw <= brw_next; counter++.
- Overflow capture: when counter == N-1 (the MSB step), ovf <= brw ^ brw_next, i.e. borrow into MSB xor borrow out of MSB.
- End of RUN: when counter == N-1, the next state is DONE. Exactly N RUN cycles.
- DONE:
  - out_valid=1; bout holds the final borrow; zero is registered as (result == 0).
  - d, bout, ovf and zero stay stable while out_valid=1 and out_ready=0.
  - On out_ready=1: go to IDLE, out_valid drops the next cycle.
  - d, bout, ovf and zero keep their last values in IDLE until the next DONE.
- Latency: accept edge at cycle t gives out_valid=1 in cycle t+N+1.
- Throughput: with out_ready held high, one result per N+2 cycles.
- in_ready=0 in RUN and DONE. in_valid and operand changes during RUN/DONE are ignored; no overlapping transactions.
- in_valid and out_ready are only meaningful in their own states; there are no simultaneous accept/complete hazards.
- in_valid held high continuously: a new accept occurs on the first IDLE cycle after each DONE handshake.
- Width rules: d is the N LSBs of the difference; the borrow chain is exactly 1 bit; no saturation.

Decomposition:
- Shared package (arith_pkg):
  - typedef enum logic [1:0] {IDLE, RUN, DONE} serial_state_e.
  - Function cnt_width(N) returning $clog2(N+1).
- Sub-module full_subtractor (x, y, bi -> diff, bo): the purely combinational cell used for the per-bit step. It mirrors the team's full-adder cell and is instantiated once.
- Top serial_subtractor owns the FSM, shift registers, borrow flop, counter and flag registers.

Test Plan (N=8):
- a=0x35, b=0x12, bin=0 -> d=0x23, bout=0, ovf=0, zero=0; out_valid rises exactly 9 cycles after the accept edge.
- a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1, ovf=0, zero=0. Then a=0x80, b=0x01 -> d=0x7F, bout=0, ovf=1.
- a=0x5A, b=0x5A, bin=0 -> d=0x00, zero=1, bout=0. Same operands with bin=1 -> d=0xFF, bout=1, zero=0.
- Backpressure: result 0x23 pending with out_ready=0 for 5 cycles -> out_valid=1, d=0x23 stable and in_ready=0 throughout; in_valid pulses are ignored. out_ready=1 -> IDLE next cycle.
- Reset mid-RUN: assert rst after 3 RUN cycles -> next cycle out_valid=0, in_ready=1, d=0, bout=0. A new transaction a=0x10, b=0x01 then yields d=0x0F.
- Random regression: 1000 random {a, b, bin} with random out_ready stalls -> every result matches the reference model (a - b - bin) mod 256 and its borrow/ovf/zero flags.
